// File: rtl/smac_accum.sv
// rtl/smac_accum.sv - signed accumulate, round and saturate stage for a product stream
// Sums beats until in_last or MAXLEN, then presents one rounded, clamped result per vector.
module smac_accum #(
  parameter  int IWIDTH = 16,
  parameter  int GUARD  = 8,
  parameter  int OWIDTH = 16,
  parameter  int SHIFT  = 0,
  parameter  int MAXLEN = 256,
  localparam int AWIDTH = IWIDTH + GUARD,
  localparam int CWIDTH = $clog2(MAXLEN + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [IWIDTH-1:0] in_data,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OWIDTH-1:0] out_data,
  output logic        [CWIDTH-1:0] out_count,
  output logic                     out_sat,
  output logic                     out_trunc
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ACCUM = 1'b1;

  localparam logic signed [AWIDTH:0] OMAX = (AWIDTH+1)'((longint'(1) << (OWIDTH - 1)) - 1);
  localparam logic signed [AWIDTH:0] OMIN = -OMAX - (AWIDTH+1)'(1);

  logic [0:0]               state_q, state_d;
  logic [AWIDTH-1:0]        acc_q, acc_d;
  logic [CWIDTH-1:0]        count_q, count_d;
  logic                     acc_sat_q, acc_sat_d;

  logic                     out_valid_q;
  logic signed [OWIDTH-1:0] out_data_q;
  logic [CWIDTH-1:0]        out_count_q;
  logic                     out_sat_q;
  logic                     out_trunc_q;

  logic                     accept;
  logic                     terminal;
  logic [AWIDTH-1:0]        acc_base;
  logic [CWIDTH-1:0]        count_base;
  logic [AWIDTH:0]          sum_wide;
  logic [AWIDTH-1:0]        acc_clamped;
  logic                     acc_ovf;
  logic [CWIDTH-1:0]        count_inc;
  logic signed [AWIDTH:0]   shifted;
  logic                     out_clamp;
  logic signed [OWIDTH-1:0] res_data;

  assign in_ready = !(out_valid_q && !out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    acc_base   = (state_q == ST_ACCUM) ? acc_q : '0;
    count_base = (state_q == ST_ACCUM) ? count_q : '0;
    // One extra bit exposes wrap of the AWIDTH accumulator as a sign disagreement.
    sum_wide   = {acc_base[AWIDTH-1], acc_base} + {{(GUARD + 1){in_data[IWIDTH-1]}}, in_data};
    acc_ovf    = sum_wide[AWIDTH] != sum_wide[AWIDTH-1];
    if (!acc_ovf) begin
      acc_clamped = sum_wide[AWIDTH-1:0];
    end else if (sum_wide[AWIDTH]) begin
      acc_clamped = {1'b1, {(AWIDTH - 1){1'b0}}};
    end else begin
      acc_clamped = {1'b0, {(AWIDTH - 1){1'b1}}};
    end
    count_inc = count_base + CWIDTH'(1);
    terminal  = in_last || (count_inc == CWIDTH'(MAXLEN));
  end

  generate
    if (SHIFT > 0) begin : g_round
      localparam logic signed [AWIDTH:0] RND = (AWIDTH+1)'(1) << (SHIFT - 1);
      assign shifted = ($signed({acc_clamped[AWIDTH-1], acc_clamped}) + RND) >>> SHIFT;
    end else begin : g_pass
      assign shifted = $signed({acc_clamped[AWIDTH-1], acc_clamped});
    end
  endgenerate

  always_comb begin
    out_clamp = 1'b0;
    res_data  = shifted[OWIDTH-1:0];
    if (shifted > OMAX) begin
      out_clamp = 1'b1;
      res_data  = OMAX[OWIDTH-1:0];
    end else if (shifted < OMIN) begin
      out_clamp = 1'b1;
      res_data  = OMIN[OWIDTH-1:0];
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    count_d   = count_q;
    acc_sat_d = acc_sat_q;
    if (accept) begin
      if (terminal) begin
        state_d   = ST_IDLE;
        acc_d     = '0;
        count_d   = '0;
        acc_sat_d = 1'b0;
      end else begin
        state_d   = ST_ACCUM;
        acc_d     = acc_clamped;
        count_d   = count_inc;
        acc_sat_d = acc_sat_q | acc_ovf;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      count_q     <= '0;
      acc_sat_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_sat_q   <= 1'b0;
      out_trunc_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      acc_sat_q <= acc_sat_d;
      if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
      // A terminal beat can only be accepted when the output slot is free or draining.
      if (accept && terminal) begin
        out_valid_q <= 1'b1;
        out_data_q  <= res_data;
        out_count_q <= count_inc;
        out_sat_q   <= acc_sat_q | acc_ovf | out_clamp;
        out_trunc_q <= !in_last;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;
  assign out_sat   = out_sat_q;
  assign out_trunc = out_trunc_q;

endmodule

// File: tb/tb_smac_accum.sv
// tb/tb_smac_accum.sv - randomized and directed bench for smac_accum against a behavioural model
// Three instances: defaults, MAXLEN=4, and SHIFT=2 with a narrow accumulator.
module tb_smac_accum;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              iv[3], il[3], ordy[3];
  logic signed [15:0] id[3];
  logic              ir[3], ov[3], os[3], ot[3];
  logic signed [15:0] od[3];
  logic [8:0]        oc0, oc2;
  logic [2:0]        oc1;

  int P_MLEN[3] = '{256, 4, 256};
  int P_SH[3]   = '{0, 0, 2};
  int P_G[3]    = '{8, 8, 1};

  longint m_acc[3];
  int     m_cnt[3];
  bit     m_sat[3];
  bit     e_valid[3];
  longint e_data[3];
  int     e_count[3];
  bit     e_sat[3], e_trunc[3];

  int  n_tests = 0;
  int  n_fail  = 0;
  bit  started = 1'b0;

  smac_accum u0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]), .in_last(il[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]), .out_count(oc0),
    .out_sat(os[0]), .out_trunc(ot[0])
  );
  smac_accum #(.MAXLEN(4)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]), .in_last(il[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]), .out_count(oc1),
    .out_sat(os[1]), .out_trunc(ot[1])
  );
  smac_accum #(.SHIFT(2), .GUARD(1)) u2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(id[2]), .in_last(il[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od[2]), .out_count(oc2),
    .out_sat(os[2]), .out_trunc(ot[2])
  );

  function automatic longint dcount(input int k);
    case (k)
      0:       return longint'(oc0);
      1:       return longint'(oc1);
      default: return longint'(oc2);
    endcase
  endfunction

  task automatic chk(input string nm, input int k, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s[%0d] @%0t: got %0d expected %0d", nm, k, $time, act, exp);
    end
  endtask

  // Reference: saturating running sum per vector, result formed when the vector closes.
  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        m_acc[k] = 0; m_cnt[k] = 0; m_sat[k] = 0;
        e_valid[k] = 0; e_data[k] = 0; e_count[k] = 0; e_sat[k] = 0; e_trunc[k] = 0;
      end else begin
        bit     rdy;
        longint amax, amin, r;
        bit     sat;
        rdy  = !(e_valid[k] && !ordy[k]);
        amax = (longint'(1) << (15 + P_G[k])) - 1;
        amin = -amax - 1;
        if (e_valid[k] && ordy[k]) e_valid[k] = 0;
        if (iv[k] && rdy) begin
          m_acc[k] += longint'(id[k]);
          if (m_acc[k] > amax) begin m_acc[k] = amax; m_sat[k] = 1; end
          if (m_acc[k] < amin) begin m_acc[k] = amin; m_sat[k] = 1; end
          m_cnt[k]++;
          if (il[k] || m_cnt[k] == P_MLEN[k]) begin
            r = m_acc[k];
            if (P_SH[k] > 0) r = (r + (longint'(1) << (P_SH[k] - 1))) >>> P_SH[k];
            sat = m_sat[k];
            if (r > 32767)  begin r = 32767;  sat = 1; end
            if (r < -32768) begin r = -32768; sat = 1; end
            e_valid[k] = 1; e_data[k] = r; e_count[k] = m_cnt[k];
            e_sat[k] = sat; e_trunc[k] = !il[k];
            m_acc[k] = 0; m_cnt[k] = 0; m_sat[k] = 0;
          end
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 3; k++) begin
        chk("in_ready", k, longint'(ir[k]), longint'(!(e_valid[k] && !ordy[k])));
        chk("out_valid", k, longint'(ov[k]), longint'(e_valid[k]));
        if (e_valid[k]) begin
          chk("out_data", k, longint'(od[k]), e_data[k]);
          chk("out_count", k, dcount(k), longint'(e_count[k]));
          chk("out_sat", k, longint'(os[k]), longint'(e_sat[k]));
          chk("out_trunc", k, longint'(ot[k]), longint'(e_trunc[k]));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic send(input int k, input int d, input bit last);
    iv[k] = 1'b1; id[k] = 16'(d); il[k] = last;
    tick();
  endtask

  task automatic idle(input int k);
    iv[k] = 1'b0; il[k] = 1'b0;
  endtask

  task automatic lit_out(input string nm, input int k, input int d, input int c);
    chk({nm, "_valid"}, k, longint'(ov[k]), 1);
    chk({nm, "_data"}, k, longint'(od[k]), longint'(d));
    chk({nm, "_count"}, k, dcount(k), longint'(c));
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0; il[k] = 1'b0; id[k] = '0; ordy[k] = 1'b1;
    end
    tick();
    started = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("rst_valid", k, longint'(ov[k]), 0);
      chk("rst_data", k, longint'(od[k]), 0);
      chk("rst_count", k, dcount(k), 0);
      chk("rst_flags", k, longint'({os[k], ot[k]}), 0);
    end

    send(0, 3, 0); send(0, -5, 0); send(0, 10, 1); idle(0);
    lit_out("sum8", 0, 8, 3);
    chk("sum8_flags", 0, longint'({os[0], ot[0]}), 0);
    chk("model_sum8", 0, e_data[0], 8);

    send(0, -7, 1); lit_out("neg7", 0, -7, 1);
    send(0, 1, 1);  lit_out("b2b1", 0, 1, 1);
    send(0, 2, 1);  lit_out("b2b2", 0, 2, 1);
    send(0, 3, 1);  lit_out("b2b3", 0, 3, 1);

    send(0, 32767, 0); send(0, 1, 1);
    lit_out("satp", 0, 32767, 2); chk("satp_flag", 0, longint'(os[0]), 1);
    send(0, -32768, 0); send(0, -1, 1);
    lit_out("satn", 0, -32768, 2); chk("satn_flag", 0, longint'(os[0]), 1);
    send(0, 5, 1); idle(0);
    lit_out("sticky", 0, 5, 1); chk("sticky_flag", 0, longint'(os[0]), 0);
    tick();

    ordy[0] = 1'b0;
    send(0, 3, 0); send(0, 5, 1);
    for (int i = 0; i < 5; i++) begin
      send(0, 100, 1);
      chk("stall_ready", 0, longint'(ir[0]), 0);
      chk("stall_data", 0, longint'(od[0]), 8);
    end
    ordy[0] = 1'b1;
    #1;
    chk("release_ready", 0, longint'(ir[0]), 1);
    tick(); idle(0);
    lit_out("after_stall", 0, 100, 1);
    tick();
    chk("drained", 0, longint'(ov[0]), 0);

    for (int i = 0; i < 4; i++) send(1, 1, 0);
    lit_out("trunc", 1, 4, 4); chk("trunc_flag", 1, longint'(ot[1]), 1);
    send(1, 1, 1); idle(1);
    lit_out("after_trunc", 1, 1, 1); chk("after_trunc_flag", 1, longint'(ot[1]), 0);

    send(2, 6, 1);  lit_out("shr6", 2, 2, 1);
    send(2, -6, 1); lit_out("shrm6", 2, -1, 1); chk("model_shrm6", 2, e_data[2], -1);
    send(2, 5, 1);  idle(2); lit_out("shr5", 2, 1, 1);

    ordy[0] = 1'b0;
    send(0, 9, 1);
    ordy[0] = 1'b1;
    send(0, 100, 0); send(0, 100, 0); idle(0);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_mid_valid", 0, longint'(ov[0]), 0);
    send(0, 1, 1); idle(0);
    lit_out("post_rst", 0, 1, 1);

    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 499) == 0);
      for (int k = 0; k < 3; k++) begin
        int sel;
        iv[k]   = ($urandom_range(0, 3) != 0);
        il[k]   = ($urandom_range(0, 4) == 0);
        ordy[k] = ($urandom_range(0, 3) != 0);
        sel = int'($urandom_range(0, 3));
        case (sel)
          0:       id[k] = 16'($urandom);
          1:       id[k] = 16'sh7fff;
          2:       id[k] = -16'sh8000;
          default: id[k] = 16'($signed(int'($urandom_range(0, 40))) - 20);
        endcase
      end
      tick();
    end
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      idle(k); ordy[k] = 1'b1;
    end
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
